// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: steps the shared ALU, memory port and register
// file through FETCH/DECODE/EXEC/MEM/WB. It also handles memory timeouts and counts retired instructions.
module multicycle_control_fsm #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [31:0] retired,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] C_ILLEGAL = 2'b01;
    localparam logic [1:0] C_TIMEOUT = 2'b10;

    // Trap fires on the wait cycle whose increment would make the counter hit TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_nxt;
    logic [6:0] opcode_q;
    logic [7:0] wait_cnt;
    logic [1:0] cause_nxt;
    logic       wait_expired;

    assign state        = state_q;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_comb begin
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        wb_sel        = 2'b00;
        instr_done    = 1'b0;
        trap          = 1'b0;
        state_nxt     = state_q;
        cause_nxt     = trap_cause;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_expired) begin
                    state_nxt = S_TRAP;
                    cause_nxt = C_TIMEOUT;
                end
            end
            S_DECODE: begin
                // Branch/jump target lands in ALUOut ahead of EXEC.
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LUI: state_nxt = S_WB;
                    OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL: state_nxt = S_EXEC;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = C_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_nxt = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_nxt = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_nxt = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a     = 1'b1;
                        alu_op        = 2'b11;
                        pc_write_cond = 1'b1;
                        pc_src        = 1'b1;
                        instr_done    = 1'b1;
                        state_nxt     = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        state_nxt = S_WB;
                    end
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = C_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_read  = (opcode_q == OP_LD);
                mem_write = (opcode_q == OP_ST);
                if (mem_ready) begin
                    if (opcode_q == OP_LD) begin
                        state_nxt = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end else if (wait_expired) begin
                    state_nxt = S_TRAP;
                    cause_nxt = C_TIMEOUT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
                case (opcode_q)
                    OP_LD:   wb_sel = 2'b01;
                    OP_JAL:  wb_sel = 2'b10;
                    OP_LUI:  wb_sel = 2'b11;
                    default: wb_sel = 2'b00;
                endcase
            end
            S_TRAP: trap = 1'b1;
            default: begin
                state_nxt = S_TRAP;
                cause_nxt = C_ILLEGAL;
            end
        endcase

        // Reset abandons the instruction without any side-effect strobes.
        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            reg_write     = 1'b0;
            wb_sel        = 2'b00;
            instr_done    = 1'b0;
            trap          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            opcode_q   <= 7'd0;
            wait_cnt   <= 8'd0;
            retired    <= 32'd0;
            trap_cause <= 2'b00;
        end else begin
            state_q    <= state_nxt;
            trap_cause <= cause_nxt;
            if (state_q == S_DECODE)
                opcode_q <= opcode;
            if (state_nxt != state_q)
                wait_cnt <= 8'd0;
            else if (mem_req && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (instr_done)
                retired <= retired + 32'd1;
        end
    end

endmodule
